// File: rtl/shower_pkg.sv
// Shared definitions for the anode shower transmit path.
// Contents: shower code constants, FSM state encoding, default widths.
package shower_pkg;

  localparam int STRETCH_W_DEF = 4;
  localparam int DEAD_W_DEF    = 5;
  localparam int CNT_W_DEF     = 16;

  localparam logic [1:0] SH_NONE    = 2'd0;
  localparam logic [1:0] SH_LOOSE   = 2'd1;
  localparam logic [1:0] SH_NOMINAL = 2'd2;
  localparam logic [1:0] SH_TIGHT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

endpackage

// File: rtl/sh_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   clr_i     : clear to zero (wins over inc_i)
//   inc_i     : increment by one, holding at all-ones
//   cnt_o     : current count
module sh_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/shower_tx.sv
// Shower code conditioner for the ALCT-to-OTMB trigger link.
// Stretches an accepted code for max(stretch,1) BX, upgrades it when a
// higher code arrives during the stretch, then suppresses input for
// deadtime BX. Counts every code sent (new sequences and upgrades).
// Ports:
//   clk, rst      : BX clock, synchronous active-high reset
//   shower_int    : per-BX code from the detector (0 none .. 3 tight)
//   enable        : allows IDLE -> HOLD
//   stretch       : hold length in BX (0 treated as 1)
//   deadtime      : suppression length in BX after a stretch
//   cnt_clear     : clears all sent-code counters
//   shower_out    : registered conditioned code
//   shower_busy   : registered, high while holding or dead
//   cnt_*         : saturating sent-code counters
//
// state   | meaning
// IDLE    | waiting for an enabled nonzero code
// HOLD    | driving latched code, upgrades accepted
// DEAD    | output zero, input ignored
module shower_tx
  import shower_pkg::*;
#(
  parameter int STRETCH_W = STRETCH_W_DEF,
  parameter int DEAD_W    = DEAD_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           shower_int,
  input  logic                 enable,
  input  logic [STRETCH_W-1:0] stretch,
  input  logic [DEAD_W-1:0]    deadtime,
  input  logic                 cnt_clear,
  output logic [1:0]           shower_out,
  output logic                 shower_busy,
  output logic [CNT_W-1:0]     cnt_loose,
  output logic [CNT_W-1:0]     cnt_nominal,
  output logic [CNT_W-1:0]     cnt_tight
);

  state_e               state_q, state_d;
  logic [1:0]           code_q, code_d;
  logic [STRETCH_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DEAD_W-1:0]    dead_cnt_q, dead_cnt_d;
  logic [1:0]           out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 inc_en;
  logic                 trig;
  logic [STRETCH_W-1:0] hold_load;

  assign trig      = enable && (shower_int != SH_NONE);
  assign hold_load = (stretch == '0) ? STRETCH_W'(1) : stretch;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    hold_cnt_d = hold_cnt_q;
    dead_cnt_d = dead_cnt_q;
    inc_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d    = ST_HOLD;
          code_d     = shower_int;
          hold_cnt_d = hold_load;
          inc_en     = 1'b1;
        end
      end
      ST_HOLD: begin
        if (shower_int > code_q) begin
          code_d     = shower_int;
          hold_cnt_d = hold_load;
          inc_en     = 1'b1;
        end else if (hold_cnt_q <= STRETCH_W'(1)) begin
          if (deadtime != '0) begin
            state_d    = ST_DEAD;
            dead_cnt_d = deadtime;
            code_d     = SH_NONE;
            hold_cnt_d = '0;
          end else if (trig) begin
            // With no dead time the exit cycle is the IDLE re-entry cycle,
            // so a code present now starts a fresh sequence seamlessly.
            code_d     = shower_int;
            hold_cnt_d = hold_load;
            inc_en     = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            code_d     = SH_NONE;
            hold_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - STRETCH_W'(1);
        end
      end
      ST_DEAD: begin
        if (dead_cnt_q <= DEAD_W'(1)) begin
          state_d    = ST_IDLE;
          dead_cnt_d = '0;
        end else begin
          dead_cnt_d = dead_cnt_q - DEAD_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        code_d     = SH_NONE;
        hold_cnt_d = '0;
        dead_cnt_d = '0;
      end
    endcase
    out_d  = (state_d == ST_HOLD) ? code_d : SH_NONE;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      code_q     <= SH_NONE;
      hold_cnt_q <= '0;
      dead_cnt_q <= '0;
      out_q      <= SH_NONE;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      hold_cnt_q <= hold_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
    end
  end

  assign shower_out  = out_q;
  assign shower_busy = busy_q;

  sh_sat_cnt #(.W(CNT_W)) u_cnt_loose (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clear),
    .inc_i (inc_en && (shower_int == SH_LOOSE)),
    .cnt_o (cnt_loose)
  );

  sh_sat_cnt #(.W(CNT_W)) u_cnt_nominal (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clear),
    .inc_i (inc_en && (shower_int == SH_NOMINAL)),
    .cnt_o (cnt_nominal)
  );

  sh_sat_cnt #(.W(CNT_W)) u_cnt_tight (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clear),
    .inc_i (inc_en && (shower_int == SH_TIGHT)),
    .cnt_o (cnt_tight)
  );

endmodule

// File: tb/tb_shower_tx.sv
// Self-checking bench for shower_tx: directed scenarios with fixed
// expectations, then randomized traffic against a timestamp-based model.
module tb_shower_tx;

  localparam int SW   = 4;
  localparam int DW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    shower_int;
  logic          enable;
  logic [SW-1:0] stretch;
  logic [DW-1:0] deadtime;
  logic          cnt_clear;
  logic [1:0]    shower_out;
  logic          shower_busy;
  logic [CW-1:0] cnt_loose, cnt_nominal, cnt_tight;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: absolute cycle stamps instead of states
  int n;
  int m_hold_last, m_dead_last, m_code;
  int m_cnt[4];
  int exp_out, exp_busy;

  shower_tx #(.STRETCH_W(SW), .DEAD_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .shower_int  (shower_int),
    .enable      (enable),
    .stretch     (stretch),
    .deadtime    (deadtime),
    .cnt_clear   (cnt_clear),
    .shower_out  (shower_out),
    .shower_busy (shower_busy),
    .cnt_loose   (cnt_loose),
    .cnt_nominal (cnt_nominal),
    .cnt_tight   (cnt_tight)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic dstep(input logic [1:0] x, input int eo, input int eb, input string tag);
    shower_int = x;
    cyc();
    chk({tag, "_out"}, 32'(shower_out), eo);
    chk({tag, "_busy"}, 32'(shower_busy), eb);
  endtask

  task automatic clr_cnt();
    shower_int = 2'd0;
    cnt_clear  = 1'b1;
    cyc();
    cnt_clear  = 1'b0;
  endtask

  task automatic m_start(input int code, input int len);
    m_code      = code;
    m_hold_last = n + len;
    m_cnt[code] = (m_cnt[code] < CMAX) ? m_cnt[code] + 1 : m_cnt[code];
  endtask

  // Computes the outputs expected after the coming edge from current inputs.
  task automatic model_step();
    int len;
    len = (stretch == 0) ? 1 : int'(stretch);
    if (rst) begin
      m_hold_last = -1;
      m_dead_last = -1;
      m_code      = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      if (n <= m_hold_last) begin
        if (int'(shower_int) > m_code) m_start(int'(shower_int), len);
        else if (n == m_hold_last) begin
          if (deadtime != 0) m_dead_last = n + int'(deadtime);
          else if (enable && shower_int != 0) m_start(int'(shower_int), len);
        end
      end else if (n > m_dead_last) begin
        if (enable && shower_int != 0) m_start(int'(shower_int), len);
      end
      if (cnt_clear) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end
    n++;
    exp_out  = (n <= m_hold_last) ? m_code : 0;
    exp_busy = ((n <= m_hold_last) || (n <= m_dead_last)) ? 1 : 0;
  endtask

  initial begin
    rst = 1'b1; shower_int = 2'd0; enable = 1'b1;
    stretch = '0; deadtime = '0; cnt_clear = 1'b0;
    cyc(); cyc();
    chk("rst_out", 32'(shower_out), 0);
    chk("rst_busy", 32'(shower_busy), 0);
    chk("rst_cnt_l", 32'(cnt_loose), 0);
    chk("rst_cnt_t", 32'(cnt_tight), 0);
    rst = 1'b0;

    // basic stretch
    stretch = 4'd3; deadtime = 5'd2;
    dstep(2'd2, 2, 1, "basic1");
    dstep(2'd0, 2, 1, "basic2");
    dstep(2'd0, 2, 1, "basic3");
    dstep(2'd0, 0, 1, "basic4");
    dstep(2'd0, 0, 1, "basic5");
    dstep(2'd0, 0, 0, "basic6");
    chk("basic_cnt_n", 32'(cnt_nominal), 1);

    // upgrade, lower code ignored
    clr_cnt();
    stretch = 4'd4; deadtime = 5'd0;
    dstep(2'd1, 1, 1, "upg1");
    dstep(2'd0, 1, 1, "upg2");
    dstep(2'd3, 3, 1, "upg3");
    dstep(2'd0, 3, 1, "upg4");
    dstep(2'd2, 3, 1, "upg5");
    dstep(2'd0, 3, 1, "upg6");
    dstep(2'd0, 0, 0, "upg7");
    chk("upg_cnt_l", 32'(cnt_loose), 1);
    chk("upg_cnt_n", 32'(cnt_nominal), 0);
    chk("upg_cnt_t", 32'(cnt_tight), 1);

    // dead time suppression
    clr_cnt();
    stretch = 4'd1; deadtime = 5'd3;
    dstep(2'd3, 3, 1, "dead1");
    dstep(2'd0, 0, 1, "dead2");
    dstep(2'd3, 0, 1, "dead3");
    dstep(2'd3, 0, 1, "dead4");
    dstep(2'd3, 0, 0, "dead5");
    dstep(2'd3, 3, 1, "dead6");
    dstep(2'd0, 0, 1, "dead7");
    chk("dead_cnt_t", 32'(cnt_tight), 2);
    for (int i = 0; i < 4; i++) dstep(2'd0, 0, (i < 2) ? 1 : 0, "dead_drain");

    // zero configs: back-to-back retrigger
    clr_cnt();
    stretch = 4'd0; deadtime = 5'd0;
    dstep(2'd1, 1, 1, "zero1");
    dstep(2'd1, 1, 1, "zero2");
    dstep(2'd1, 1, 1, "zero3");
    dstep(2'd0, 0, 0, "zero4");
    chk("zero_cnt_l", 32'(cnt_loose), 3);

    // saturation and clear-wins
    shower_int = 2'd3;
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_cnt_t", 32'(cnt_tight), CMAX);
    dstep(2'd0, 0, 0, "sat_idle");
    chk("sat_hold_t", 32'(cnt_tight), CMAX);
    shower_int = 2'd1; cnt_clear = 1'b1;
    cyc();
    cnt_clear = 1'b0;
    chk("clr_win_l", 32'(cnt_loose), 0);
    chk("clr_win_t", 32'(cnt_tight), 0);
    chk("clr_win_out", 32'(shower_out), 1);
    dstep(2'd0, 0, 0, "clr_idle");

    // reset mid-HOLD
    stretch = 4'd5;
    dstep(2'd2, 2, 1, "rsth1");
    dstep(2'd0, 2, 1, "rsth2");
    rst = 1'b1;
    dstep(2'd0, 0, 0, "rsth3");
    chk("rsth_cnt_n", 32'(cnt_nominal), 0);
    rst = 1'b0;

    // enable low in IDLE
    enable = 1'b0;
    dstep(2'd3, 0, 0, "en_off1");
    dstep(2'd2, 0, 0, "en_off2");
    chk("en_off_cnt_t", 32'(cnt_tight), 0);

    // enable dropped mid-HOLD, upgrade still taken
    stretch = 4'd3; enable = 1'b1;
    dstep(2'd1, 1, 1, "en_drop1");
    enable = 1'b0;
    dstep(2'd0, 1, 1, "en_drop2");
    dstep(2'd2, 2, 1, "en_drop3");
    dstep(2'd0, 2, 1, "en_drop4");
    dstep(2'd0, 2, 1, "en_drop5");
    dstep(2'd0, 0, 0, "en_drop6");
    chk("en_drop_cnt_n", 32'(cnt_nominal), 1);

    // randomized traffic against the model
    n = 0;
    rst = 1'b1; enable = 1'b1;
    model_step();
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      shower_int = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      enable     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) stretch = SW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) deadtime = DW'($urandom_range(0, 7));
      cnt_clear  = ($urandom_range(0, 49) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      model_step();
      cyc();
      chk("rnd_out", 32'(shower_out), exp_out);
      chk("rnd_busy", 32'(shower_busy), exp_busy);
      chk("rnd_cnt_l", 32'(cnt_loose), m_cnt[1]);
      chk("rnd_cnt_n", 32'(cnt_nominal), m_cnt[2]);
      chk("rnd_cnt_t", 32'(cnt_tight), m_cnt[3]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
